// File: rtl/usb_tx_encoder.sv
// +--------------------------------------------------------------------------+
// | Module   : usb_tx_encoder                                                 |
// | Purpose  : USB full-speed transmit line encoder. Accepts packet bytes     |
// |            over a valid/ready handshake, prepends SYNC, serialises LSB    |
// |            first, bit-stuffs, NRZI-encodes and appends EOP (SE0,SE0,J).   |
// | Ports    : clk, n_rst (async, active-low)                                 |
// |            tx_valid/tx_data/tx_last/tx_ready : byte handshake             |
// |            tx_busy  : packet on the line                                  |
// |            tx_done  : one-cycle pulse in the final EOP cycle              |
// |            tx_error : one-cycle pulse on underrun                         |
// |            d_plus/d_minus : registered differential line                  |
// | Config   : USB_TX_BIT_STUFF_EN defined enables bit stuffing; undefined    |
// |            sends raw NRZI data (PHY/eye testing).                         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SYNC      = 3'd1,
    S_DATA      = 3'd2,
`ifdef USB_TX_BIT_STUFF_EN
    S_STUFF     = 3'd3,
`endif
    S_EOP_SE0_1 = 3'd4,
    S_EOP_SE0_2 = 3'd5,
    S_EOP_J     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             cur_last_q, cur_last_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_full_q, hold_full_d;
  logic             last_acc_q, last_acc_d;
  logic             dp_q, dp_d;
  logic             dm_q, dm_d;
`ifdef USB_TX_BIT_STUFF_EN
  logic [2:0]       ones_q, ones_d;
`endif

  logic       xfer;
  logic       bit_end;
  logic       next_step;
  logic       goto_eop;
  logic       emit_en;
  logic       emit_bit;
  logic [7:0] load_data;
  logic       load_last;

  assign tx_ready = !hold_full_q && !last_acc_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign d_plus   = dp_q;
  assign d_minus  = dm_q;
  assign xfer     = tx_valid && tx_ready;
  assign bit_end  = (clk_cnt_q == CNT_MAX);

  // A byte handed over in the boundary cycle itself bypasses the holding
  // register so the line sees no gap.
  assign load_data = hold_full_q ? hold_data_q : tx_data;
  assign load_last = hold_full_q ? hold_last_q : tx_last;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : clk_cnt_q + CNT_W'(1);
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    cur_last_d  = cur_last_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    last_acc_d  = last_acc_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
`ifdef USB_TX_BIT_STUFF_EN
    ones_d      = ones_q;
`endif
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    next_step   = 1'b0;
    goto_eop    = 1'b0;
    emit_en     = 1'b0;
    emit_bit    = 1'b0;

    if (xfer) begin
      hold_data_d = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
      if (tx_last) last_acc_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d    = S_SYNC;
          shift_d    = 8'h80;
          bit_idx_d  = 3'd0;
          cur_last_d = 1'b0;
          emit_en    = 1'b1;
          emit_bit   = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (bit_end) begin
`ifdef USB_TX_BIT_STUFF_EN
          if (ones_q == 3'd6) begin
            state_d  = S_STUFF;
            emit_en  = 1'b1;
            emit_bit = 1'b0;
          end else
`endif
            next_step = 1'b1;
        end
      end
`ifdef USB_TX_BIT_STUFF_EN
      S_STUFF: begin
        if (bit_end) next_step = 1'b1;
      end
`endif
      S_EOP_SE0_1: begin
        if (bit_end) state_d = S_EOP_SE0_2;
      end
      S_EOP_SE0_2: begin
        if (bit_end) begin
          state_d = S_EOP_J;
          dp_d    = 1'b1;
          dm_d    = 1'b0;
        end
      end
      S_EOP_J: begin
        if (bit_end) begin
          state_d     = S_IDLE;
          tx_done     = 1'b1;
          last_acc_d  = 1'b0;
          hold_full_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Advance to the next bit, or resolve the byte boundary once bit 7
    // (and any stuff bit that followed it) has been sent.
    if (next_step) begin
      if (bit_idx_q != 3'd7) begin
        state_d   = (state_q == S_SYNC) ? S_SYNC : S_DATA;
        bit_idx_d = bit_idx_q + 3'd1;
        shift_d   = {1'b0, shift_q[7:1]};
        emit_en   = 1'b1;
        emit_bit  = shift_q[1];
      end else if (cur_last_q) begin
        goto_eop = 1'b1;
      end else if (hold_full_q || xfer) begin
        state_d     = S_DATA;
        shift_d     = load_data;
        cur_last_d  = load_last;
        bit_idx_d   = 3'd0;
        hold_full_d = 1'b0;
        emit_en     = 1'b1;
        emit_bit    = load_data[0];
      end else begin
        tx_error = 1'b1;
        goto_eop = 1'b1;
      end
    end

    // Packet is closed once EOP starts, so nothing is accepted until IDLE.
    if (goto_eop) begin
      state_d    = S_EOP_SE0_1;
      dp_d       = 1'b0;
      dm_d       = 1'b0;
      last_acc_d = 1'b1;
    end

    // NRZI: a 0 swaps J/K, a 1 holds the line.
    if (emit_en) begin
      if (!emit_bit) begin
        dp_d = dm_q;
        dm_d = dp_q;
`ifdef USB_TX_BIT_STUFF_EN
        ones_d = 3'd0;
`endif
      end else begin
`ifdef USB_TX_BIT_STUFF_EN
        ones_d = ones_q + 3'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      cur_last_q  <= 1'b0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      last_acc_q  <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
      ones_q      <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      cur_last_q  <= cur_last_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      last_acc_q  <= last_acc_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
`ifdef USB_TX_BIT_STUFF_EN
      ones_q      <= ones_d;
`endif
    end
  end

endmodule

`default_nettype wire
